cim_macro: RTL and testbench

Parametrised clocked compute-in-memory macro. Holds a ROWS x COLS array of WBITS-bit weights, written and read through a row-addressed standard port. Computes COLS parallel dot products of one ROWS-element activation vector against the stored weight columns. Activations are processed bit-serially, LSB first, behind valid/ready handshakes. Replaces the single-column combinational PE; one instance serves a multi-output-channel tile.

---
 rtl/cim_pkg.sv | 20 ++
 rtl/cim_macro_if.sv | 37 +++
 rtl/cim_col_adder.sv | 36 +++
 rtl/cim_macro.sv | 176 +++++++++++++++++
 tb/tb_cim_macro.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cim_pkg.sv
// Shared defaults, derived-width helpers and FSM state type for the CIM macro.
package cim_pkg;

    localparam int unsigned DefRows  = 64;
    localparam int unsigned DefCols  = 4;
    localparam int unsigned DefWbits = 4;
    localparam int unsigned DefAbits = 4;

    function automatic int unsigned calc_aw(input int unsigned rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

    function automatic int unsigned calc_pw(input int unsigned wbits, input int unsigned abits,
                                            input int unsigned rows);
        return wbits + abits + calc_aw(rows);
    endfunction

    typedef enum logic [1:0] {StIdle, StCompute, StDone} state_e;

endpackage

// File: rtl/cim_macro_if.sv
// Bus bundle for cim_macro: row-addressed weight port, activation input and PSUM output.
interface cim_macro_if #(
    parameter int unsigned ROWS  = cim_pkg::DefRows,
    parameter int unsigned COLS  = cim_pkg::DefCols,
    parameter int unsigned WBITS = cim_pkg::DefWbits,
    parameter int unsigned ABITS = cim_pkg::DefAbits
);
    import cim_pkg::*;

    localparam int unsigned AW = calc_aw(ROWS);
    localparam int unsigned PW = calc_pw(WBITS, ABITS, ROWS);

    logic                    STDW;
    logic                    STDR;
    logic [AW-1:0]           STD_A;
    logic                    STD_ready;
    logic [COLS*WBITS-1:0]   weight_in;
    logic [COLS*WBITS-1:0]   weight_out;
    logic                    weight_out_valid;
    logic                    IN_valid;
    logic                    IN_ready;
    logic [ROWS*ABITS-1:0]   act_in;
    logic                    OUT_valid;
    logic                    OUT_ready;
    logic [COLS*PW-1:0]      PSUM;

    modport master (
        output STDW, STDR, STD_A, weight_in, IN_valid, act_in, OUT_ready,
        input  STD_ready, weight_out, weight_out_valid, IN_ready, OUT_valid, PSUM
    );

    modport slave (
        input  STDW, STDR, STD_A, weight_in, IN_valid, act_in, OUT_ready,
        output STD_ready, weight_out, weight_out_valid, IN_ready, OUT_valid, PSUM
    );

endinterface

// File: rtl/cim_col_adder.sv
// One weight column's bit-plane sum: adds each row weight whose activation bit is set.
// Weights are sign-extended when CIM_SIGNED_EN is defined, zero-extended otherwise.
module cim_col_adder
    import cim_pkg::*;
#(
    parameter int unsigned ROWS  = DefRows,
    parameter int unsigned WBITS = DefWbits
) (
    input  logic [ROWS*WBITS-1:0]              w_col_i,
    input  logic [ROWS-1:0]                    act_bit_i,
    output logic [WBITS+calc_aw(ROWS)-1:0]     sum_o
);

    localparam int unsigned SW = WBITS + calc_aw(ROWS);

    logic [WBITS-1:0] w;
    logic [SW-1:0]    ext;

    always_comb begin
        sum_o = '0;
        w     = '0;
        ext   = '0;
        for (int r = 0; r < ROWS; r++) begin
            w = w_col_i[r*WBITS +: WBITS];
`ifdef CIM_SIGNED_EN
            ext = {{(SW-WBITS){w[WBITS-1]}}, w};
`else
            ext = {{(SW-WBITS){1'b0}}, w};
`endif
            if (act_bit_i[r]) begin
                sum_o = sum_o + ext;
            end
        end
    end

endmodule

// File: rtl/cim_macro.sv
// Compute-in-memory macro: ROWS x COLS weight array, bit-serial activations, COLS dot products.
// Define CIM_SIGNED_EN for two's-complement weights/activations (MSB plane subtracted).
module cim_macro
    import cim_pkg::*;
#(
    parameter int unsigned ROWS  = DefRows,
    parameter int unsigned COLS  = DefCols,
    parameter int unsigned WBITS = DefWbits,
    parameter int unsigned ABITS = DefAbits
) (
    input logic       clk,
    input logic       rst,
    cim_macro_if.slave bus
);

    localparam int unsigned AW = calc_aw(ROWS);
    localparam int unsigned PW = calc_pw(WBITS, ABITS, ROWS);
    localparam int unsigned SW = WBITS + AW;
    localparam int unsigned KW = $clog2(ABITS + 1);
    localparam int unsigned DW = COLS * WBITS;

    logic [DW-1:0] mem_q [ROWS];

    state_e                      state_q, state_d;
    logic [KW-1:0]               k_q, k_d;
    logic [ROWS*ABITS-1:0]       act_q, act_d;
    logic [COLS-1:0][PW-1:0]     acc_q, acc_d;
    logic [COLS-1:0][PW-1:0]     psum_q, psum_d;
    logic [DW-1:0]               wout_q, wout_d;
    logic                        wov_q, wov_d;
    logic                        ready_q, ready_d;
    logic                        ovalid_q, ovalid_d;
    logic                        we;

    logic [COLS-1:0][ROWS*WBITS-1:0] col_w;
    logic [COLS-1:0][SW-1:0]         col_sum;
    logic [COLS-1:0][PW-1:0]         part;
    logic [ROWS-1:0]                 act_bits;
    logic [KW-1:0]                   k_sel;
    logic [PW-1:0]                   ext;

    // Column-major view of the row-major weight store.
    always_comb begin
        col_w = '0;
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                col_w[c][r*WBITS +: WBITS] = mem_q[r][c*WBITS +: WBITS];
            end
        end
    end

    // k_q reaches ABITS on the result-latch cycle; keep the bit select in range there.
    always_comb begin
        k_sel    = (k_q < KW'(ABITS)) ? k_q : '0;
        act_bits = '0;
        for (int r = 0; r < ROWS; r++) begin
            act_bits[r] = act_q[r*ABITS + int'(k_sel)];
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_col
        cim_col_adder #(
            .ROWS  (ROWS),
            .WBITS (WBITS)
        ) u_col_adder (
            .w_col_i   (col_w[c]),
            .act_bit_i (act_bits),
            .sum_o     (col_sum[c])
        );
    end

    always_comb begin
        part = '0;
        ext  = '0;
        for (int c = 0; c < COLS; c++) begin
`ifdef CIM_SIGNED_EN
            ext = {{(PW-SW){col_sum[c][SW-1]}}, col_sum[c]};
`else
            ext = {{(PW-SW){1'b0}}, col_sum[c]};
`endif
            part[c] = ext << k_sel;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        act_d   = act_q;
        acc_d   = acc_q;
        psum_d  = psum_q;
        wout_d  = wout_q;
        wov_d   = 1'b0;
        we      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.STDW) begin
                    we = 1'b1;
                end else if (bus.STDR) begin
                    wout_d = mem_q[bus.STD_A];
                    wov_d  = 1'b1;
                end else if (bus.IN_valid && ready_q) begin
                    act_d   = bus.act_in;
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = StCompute;
                end
            end
            StCompute: begin
                if (k_q == KW'(ABITS)) begin
                    psum_d  = acc_q;
                    state_d = StDone;
                end else begin
                    for (int c = 0; c < COLS; c++) begin
`ifdef CIM_SIGNED_EN
                        if (k_q == KW'(ABITS - 1)) begin
                            acc_d[c] = acc_q[c] - part[c];
                        end else begin
                            acc_d[c] = acc_q[c] + part[c];
                        end
`else
                        acc_d[c] = acc_q[c] + part[c];
`endif
                    end
                    k_d = k_q + KW'(1);
                end
            end
            StDone: begin
                if (bus.OUT_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        ready_d  = (state_d == StIdle);
        ovalid_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            k_q      <= '0;
            act_q    <= '0;
            acc_q    <= '0;
            psum_q   <= '0;
            wout_q   <= '0;
            wov_q    <= 1'b0;
            ready_q  <= 1'b1;
            ovalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            act_q    <= act_d;
            acc_q    <= acc_d;
            psum_q   <= psum_d;
            wout_q   <= wout_d;
            wov_q    <= wov_d;
            ready_q  <= ready_d;
            ovalid_q <= ovalid_d;
        end
    end

    // Weight store is intentionally left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[bus.STD_A] <= bus.weight_in;
        end
    end

    assign bus.STD_ready        = ready_q;
    assign bus.IN_ready         = ready_q;
    assign bus.weight_out       = wout_q;
    assign bus.weight_out_valid = wov_q;
    assign bus.OUT_valid        = ovalid_q;
    assign bus.PSUM             = psum_q;

endmodule

// File: tb/tb_cim_macro.sv
// Directed self-checking bench for cim_macro; expected values switch with CIM_SIGNED_EN.
module tb_cim_macro;
    import cim_pkg::*;

    localparam int unsigned ROWS  = DefRows;
    localparam int unsigned COLS  = DefCols;
    localparam int unsigned WBITS = DefWbits;
    localparam int unsigned ABITS = DefAbits;
    localparam int unsigned PW    = calc_pw(WBITS, ABITS, ROWS);
    localparam int unsigned DW    = COLS * WBITS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_ps [COLS];

    always #5 clk = ~clk;

    cim_macro_if #(.ROWS(ROWS), .COLS(COLS), .WBITS(WBITS), .ABITS(ABITS)) bus ();

    cim_macro #(.ROWS(ROWS), .COLS(COLS), .WBITS(WBITS), .ABITS(ABITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_row(input int a, input logic [DW-1:0] d);
        bus.STDW      = 1'b1;
        bus.STD_A     = a[5:0];
        bus.weight_in = d;
        tick();
        bus.STDW = 1'b0;
    endtask

    task automatic fill_rows(input logic [DW-1:0] d);
        for (int r = 0; r < ROWS; r++) write_row(r, d);
    endtask

    task automatic set_acts(input logic [ABITS-1:0] v);
        for (int r = 0; r < ROWS; r++) bus.act_in[r*ABITS +: ABITS] = v;
    endtask

    // Handshake, then count cycles until OUT_valid (-1 on timeout); leaves the DUT in DONE.
    task automatic run_compute(output int lat);
        bus.IN_valid = 1'b1;
        tick();
        bus.IN_valid = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.OUT_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic release_out();
        bus.OUT_ready = 1'b1;
        tick();
        bus.OUT_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_checks += 6;
        if (bus.STD_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_std_ready: got %b want 1", bus.STD_ready);
        end
        if (bus.IN_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.IN_ready);
        end
        if (bus.OUT_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.OUT_valid);
        end
        if (bus.weight_out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_wov: got %b want 0", bus.weight_out_valid);
        end
        if (bus.weight_out !== '0) begin
            n_fail++; $display("FAIL reset_weight_out: got %h want 0", bus.weight_out);
        end
        if (bus.PSUM !== '0) begin
            n_fail++; $display("FAIL reset_psum: got %h want 0", bus.PSUM);
        end
    endtask

    task automatic test_all_ones();
        int lat;
        fill_rows(16'h1111);
        set_acts(4'hF);
        run_compute(lat);
        n_checks++;
        if (lat != ABITS + 1) begin
            n_fail++; $display("FAIL ones_latency: got %0d want %0d", lat, ABITS + 1);
        end
`ifdef CIM_SIGNED_EN
        exp_ps = '{-64, -64, -64, -64};
`else
        exp_ps = '{960, 960, 960, 960};
`endif
        for (int c = 0; c < COLS; c++) begin
            n_checks++;
            if (bus.PSUM[c*PW +: PW] !== PW'(exp_ps[c])) begin
                n_fail++;
                $display("FAIL ones_psum ch%0d: got %0d want %0d", c, bus.PSUM[c*PW +: PW],
                         PW'(exp_ps[c]));
            end
        end
        release_out();
        n_checks += 2;
        if (bus.OUT_valid !== 1'b0) begin
            n_fail++; $display("FAIL ones_out_drop: got %b want 0", bus.OUT_valid);
        end
        if (bus.IN_ready !== 1'b1) begin
            n_fail++; $display("FAIL ones_in_ready: got %b want 1", bus.IN_ready);
        end
    endtask

    task automatic test_std_rw();
        write_row(5, 16'hA3C7);
        bus.STDR  = 1'b1;
        bus.STD_A = 6'd5;
        tick();
        bus.STDR = 1'b0;
        n_checks += 2;
        if (bus.weight_out_valid !== 1'b1) begin
            n_fail++; $display("FAIL rd_pulse: got %b want 1", bus.weight_out_valid);
        end
        if (bus.weight_out !== 16'hA3C7) begin
            n_fail++; $display("FAIL rd_data: got %h want a3c7", bus.weight_out);
        end
        tick();
        n_checks += 2;
        if (bus.weight_out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rd_pulse_len: got %b want 0", bus.weight_out_valid);
        end
        if (bus.weight_out !== 16'hA3C7) begin
            n_fail++; $display("FAIL rd_hold: got %h want a3c7", bus.weight_out);
        end
        // Write and read together: write wins, no read pulse.
        bus.STDW      = 1'b1;
        bus.STDR      = 1'b1;
        bus.STD_A     = 6'd6;
        bus.weight_in = 16'h5A5A;
        tick();
        bus.STDW = 1'b0;
        bus.STDR = 1'b0;
        n_checks += 2;
        if (bus.weight_out_valid !== 1'b0) begin
            n_fail++; $display("FAIL wr_rd_no_pulse: got %b want 0", bus.weight_out_valid);
        end
        if (bus.weight_out !== 16'hA3C7) begin
            n_fail++; $display("FAIL wr_rd_no_read: got %h want a3c7", bus.weight_out);
        end
        bus.STDR  = 1'b1;
        bus.STD_A = 6'd6;
        tick();
        bus.STDR = 1'b0;
        n_checks++;
        if (bus.weight_out !== 16'h5A5A) begin
            n_fail++; $display("FAIL wr_rd_written: got %h want 5a5a", bus.weight_out);
        end
    endtask

    task automatic test_single_row();
        int lat;
        fill_rows(16'h0000);
        write_row(0, 16'h801F);
        set_acts(4'h0);
        bus.act_in[3:0] = 4'hB;
        run_compute(lat);
        n_checks++;
        if (lat != ABITS + 1) begin
            n_fail++; $display("FAIL row0_latency: got %0d want %0d", lat, ABITS + 1);
        end
`ifdef CIM_SIGNED_EN
        exp_ps = '{5, -5, 0, 40};
`else
        exp_ps = '{165, 11, 0, 88};
`endif
        for (int c = 0; c < COLS; c++) begin
            n_checks++;
            if (bus.PSUM[c*PW +: PW] !== PW'(exp_ps[c])) begin
                n_fail++;
                $display("FAIL row0_psum ch%0d: got %0d want %0d", c, bus.PSUM[c*PW +: PW],
                         PW'(exp_ps[c]));
            end
        end
    endtask

    // Runs straight after test_single_row with the result still pending.
    task automatic test_backpressure();
        logic [COLS*PW-1:0] exp_flat;
        for (int c = 0; c < COLS; c++) exp_flat[c*PW +: PW] = PW'(exp_ps[c]);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                bus.STDW      = 1'b1;
                bus.STD_A     = 6'd0;
                bus.weight_in = 16'hFFFF;
            end
            tick();
            bus.STDW = 1'b0;
            n_checks += 3;
            if (bus.OUT_valid !== 1'b1) begin
                n_fail++; $display("FAIL bp_out_valid cyc%0d: got %b want 1", i, bus.OUT_valid);
            end
            if (bus.IN_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_in_ready cyc%0d: got %b want 0", i, bus.IN_ready);
            end
            if (bus.PSUM !== exp_flat) begin
                n_fail++; $display("FAIL bp_psum cyc%0d: got %h want %h", i, bus.PSUM, exp_flat);
            end
        end
        release_out();
        bus.STDR  = 1'b1;
        bus.STD_A = 6'd0;
        tick();
        bus.STDR = 1'b0;
        n_checks++;
        if (bus.weight_out !== 16'h801F) begin
            n_fail++; $display("FAIL bp_weight_kept: got %h want 801f", bus.weight_out);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        bus.IN_valid = 1'b1;
        tick();
        bus.IN_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks += 3;
        if (bus.STD_ready !== 1'b1) begin
            n_fail++; $display("FAIL mid_rst_idle: got %b want 1", bus.STD_ready);
        end
        if (bus.OUT_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_rst_out_valid: got %b want 0", bus.OUT_valid);
        end
        if (bus.PSUM !== '0) begin
            n_fail++; $display("FAIL mid_rst_psum: got %h want 0", bus.PSUM);
        end
        run_compute(lat);
        n_checks++;
        if (lat != ABITS + 1) begin
            n_fail++; $display("FAIL mid_rst_latency: got %0d want %0d", lat, ABITS + 1);
        end
        for (int c = 0; c < COLS; c++) begin
            n_checks++;
            if (bus.PSUM[c*PW +: PW] !== PW'(exp_ps[c])) begin
                n_fail++;
                $display("FAIL mid_rst_psum ch%0d: got %0d want %0d", c, bus.PSUM[c*PW +: PW],
                         PW'(exp_ps[c]));
            end
        end
        release_out();
    endtask

    // All-(-8)/(-8) and 7/(-8); read as unsigned 8*8 and 7*8 without CIM_SIGNED_EN.
    task automatic test_extremes();
        int lat;
        int exp_a;
        int exp_b;
        exp_a = 4096;
`ifdef CIM_SIGNED_EN
        exp_b = -3584;
`else
        exp_b = 3584;
`endif
        fill_rows(16'h8888);
        set_acts(4'h8);
        run_compute(lat);
        for (int c = 0; c < COLS; c++) begin
            n_checks++;
            if (bus.PSUM[c*PW +: PW] !== PW'(exp_a)) begin
                n_fail++;
                $display("FAIL ext_neg8 ch%0d: got %0d want %0d", c, bus.PSUM[c*PW +: PW],
                         PW'(exp_a));
            end
        end
        release_out();
        fill_rows(16'h7777);
        run_compute(lat);
        for (int c = 0; c < COLS; c++) begin
            n_checks++;
            if (bus.PSUM[c*PW +: PW] !== PW'(exp_b)) begin
                n_fail++;
                $display("FAIL ext_pos7 ch%0d: got %0d want %0d", c, bus.PSUM[c*PW +: PW],
                         PW'(exp_b));
            end
        end
        release_out();
    endtask

    initial begin
        bus.STDW      = 1'b0;
        bus.STDR      = 1'b0;
        bus.STD_A     = '0;
        bus.weight_in = '0;
        bus.IN_valid  = 1'b0;
        bus.act_in    = '0;
        bus.OUT_ready = 1'b0;
        test_reset();
        test_all_ones();
        test_std_rw();
        test_single_row();
        test_backpressure();
        test_reset_mid();
        test_extremes();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
